// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the CPU datapath blocks: ALU control codes, ALUOp
//   encodings from the main decoder, and the multiply sequencer state type.
// ---------------------------------------------------------------------------
package cpu_defs;

    // ALU control codes (ALU control unit -> ALU / multiply sequencer)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    // ALUOp encodings (main decoder -> ALU control unit)
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // A multiply is requested when a valid instruction carries the MUL code.
    function automatic logic is_mul(input logic start, input logic [2:0] alu_ctrl);
        return start && (alu_ctrl == ALU_MUL);
    endfunction

endpackage

// File: rtl/ex_mul_sequencer_mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
//   Combinational shift-add step: consumes STEP multiplier bits and adds the
//   corresponding partial product of the multiplicand to the accumulator,
//   truncated to WIDTH bits.
// Ports
//   acc_i    in  WIDTH  current accumulator
//   a_i      in  WIDTH  multiplicand, already aligned to this step
//   bslice_i in  STEP   low STEP bits of the remaining multiplier
//   acc_o    out WIDTH  acc_i + a_i*bslice_i (mod 2^WIDTH)
// ---------------------------------------------------------------------------
module mul_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [STEP-1:0]  bslice_i,
    output logic [WIDTH-1:0] acc_o
);

    // One shifted copy of the multiplicand per multiplier bit in the slice;
    // a zero slice contributes nothing, so the accumulator is left unchanged.
    logic [WIDTH-1:0] term [STEP];

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_term
            assign term[gi] = bslice_i[gi] ? (a_i << gi) : '0;
        end
    endgenerate

    always_comb begin
        logic [WIDTH-1:0] sum;
        sum = acc_i;
        for (int i = 0; i < STEP; i++) begin
            sum = sum + term[i];
        end
        acc_o = sum;
    end

endmodule

// File: rtl/ex_mul_sequencer.sv
// ---------------------------------------------------------------------------
// ex_mul_sequencer
//   Multi-cycle shift-add multiplier sequencer for the EX stage. Runs beside
//   the single-cycle ALU: on a MUL it stalls the front of the pipeline for
//   WIDTH/STEP + 1 cycles, then presents the low WIDTH bits of the product
//   for exactly one cycle. Other ALU codes pass with no stall.
// Ports
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      synchronous reset, active-high
//   start_i    in   1      valid instruction in EX
//   ALUCtrl_i  in   3      ALU control code
//   data1_i    in   WIDTH  multiplicand
//   data2_i    in   WIDTH  multiplier
//   flush_i    in   1      abort any in-flight multiply
//   stall_o    out  1      freeze PC, IF/ID and ID/EX
//   done_o     out  1      data_o holds a valid product this cycle
//   data_o     out  WIDTH  product (held between results)
// WIDTH must be a multiple of STEP.
// ---------------------------------------------------------------------------
module ex_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);
    import cpu_defs::*;

    localparam int              N     = WIDTH / STEP;
    localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] acc_step;
    logic             mul_req;

    assign mul_req = is_mul(start_i, ALUCtrl_i);

    mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_mul_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .bslice_i (b_q[STEP-1:0]),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        done_d  = 1'b0;
        stall_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Stall combinationally in the detect cycle so the pipeline
                // keeps the MUL in EX while the iterations run.
                if (mul_req && !flush_i) begin
                    a_d     = data1_i;
                    b_d     = data2_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    // Abort: drop the stall now, leave data_o untouched.
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    acc_d   = acc_step;
                    a_d     = a_q << STEP;
                    b_d     = b_q >> STEP;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        data_d  = acc_step;
                    end
                end
            end
            DONE: begin
                // The instruction still in EX is the MUL just finished, so a
                // held start_i must not launch another run.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // A flush arriving in the DONE cycle cancels the result presentation.
    assign done_o = done_q && !flush_i;
    assign data_o = data_q;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ex_mul_sequencer
//   Randomised and directed bench for ex_mul_sequencer (WIDTH=32, STEP=1).
//   Expected products come from plain 64-bit multiplication; expected timing
//   from the stall/done latency rule (N+1 stall cycles, done at cycle N+1).
// ---------------------------------------------------------------------------
module tb_ex_mul_sequencer;
    import cpu_defs::*;

    localparam int W    = 32;
    localparam int STEP = 1;
    localparam int N    = W / STEP;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] dout;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_product;

    ex_mul_sequencer #(.WIDTH(W), .STEP(STEP)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (alu_ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .stall_o   (stall),
        .done_o    (done),
        .data_o    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[W-1:0];
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Issue one MUL, hold it in EX while stalled, check latency and product.
    // hold=1 keeps start_i/MUL asserted through the DONE cycle.
    task automatic issue_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input string tag);
        logic [W-1:0] expv;
        int cyc;
        int stalls;
        bit seen;
        expv   = ref_product(a, b);
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        next_cycle();
        start = 1'b1; alu_ctrl = ALU_MUL; d1 = a; d2 = b; flush = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s detect: stall=%b done=%b, required stall=1 done=0", tag, stall, done);
        end
        while (!seen && cyc <= N + 4) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                total++;
                if (cyc != N + 1) begin
                    bad++;
                    $display("FAIL %s done_cycle: got %0d, required %0d", tag, cyc, N + 1);
                end
                total++;
                if (stall !== 1'b0) begin
                    bad++;
                    $display("FAIL %s stall_in_done: got %b, required 0", tag, stall);
                end
                total++;
                if (dout !== expv) begin
                    bad++;
                    $display("FAIL %s product: got %h, required %h", tag, dout, expv);
                end
                total++;
                if (stalls != N + 1) begin
                    bad++;
                    $display("FAIL %s stall_count: got %0d, required %0d", tag, stalls, N + 1);
                end
            end else begin
                if (stall === 1'b1) stalls++;
                next_cycle();
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, N + 5);
        end
        last_product = expv;
        if (!hold) begin
            next_cycle();
            start = 1'b0; alu_ctrl = ALU_ADD;
            #1;
            total++;
            if (done !== 1'b0 || stall !== 1'b0 || dout !== last_product) begin
                bad++;
                $display("FAIL %s after_done: done=%b stall=%b data=%h, required 0 0 %h",
                         tag, done, stall, dout, last_product);
            end
        end
        $display("mul %s: %h * %h -> %h", tag, a, b, expv);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; alu_ctrl = ALU_MUL; d1 = 32'd7; d2 = 32'd6; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            total++;
            if (stall !== 1'b0 || done !== 1'b0 || dout !== '0) begin
                bad++;
                $display("FAIL reset cycle %0d: stall=%b done=%b data=%h, required 0 0 0", i, stall, done, dout);
            end
        end
        next_cycle();
        rst = 1'b0; start = 1'b0; alu_ctrl = ALU_ADD;
        #1;
        total++;
        if (stall !== 1'b0 || done !== 1'b0 || dout !== '0) begin
            bad++;
            $display("FAIL reset release: stall=%b done=%b data=%h, required 0 0 0", stall, done, dout);
        end
        last_product = '0;
        $display("reset: checked");
    endtask

    task automatic test_basic_mul();
        issue_mul(32'd7, 32'd6, 1'b0, "7x6");
    endtask

    task automatic test_truncation();
        issue_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ffff_x_ffff");
        issue_mul(32'h8000_0000, 32'd2, 1'b0, "8000_x_2");
    endtask

    task automatic test_non_mul();
        logic [2:0] codes [4];
        codes[0] = ALU_ADD; codes[1] = ALU_SUB; codes[2] = ALU_AND; codes[3] = ALU_OR;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                start = 1'b1; alu_ctrl = codes[c]; d1 = $urandom; d2 = $urandom; flush = 1'b0;
                #1;
                total++;
                if (stall !== 1'b0 || done !== 1'b0 || dout !== last_product) begin
                    bad++;
                    $display("FAIL non_mul code=%b: stall=%b done=%b data=%h, required 0 0 %h",
                             codes[c], stall, done, dout, last_product);
                end
            end
            $display("non_mul code=%b: 3 cycles", codes[c]);
        end
        next_cycle();
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_mul(32'd7, 32'd6, 1'b1, "b2b_7x6");
        issue_mul(32'd2, 32'd9, 1'b0, "b2b_2x9");
    endtask

    task automatic test_flush_busy();
        next_cycle();
        start = 1'b1; alu_ctrl = ALU_MUL; d1 = 32'd3; d2 = 32'd5; flush = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            next_cycle();
            if (cyc == 10) begin
                flush = 1'b1; start = 1'b0;
            end
            #1;
            if (cyc == 10) begin
                total++;
                if (stall !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_busy stall_same_cycle: got %b, required 0", stall);
                end
            end else if (stall !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL flush_busy stall cycle %0d: got %b, required 1", cyc, stall);
            end
        end
        for (int k = 0; k < N + 4; k++) begin
            next_cycle();
            flush = 1'b0; start = 1'b0; alu_ctrl = ALU_ADD;
            #1;
            if (k == 0) total++;
            if (done !== 1'b0 || stall !== 1'b0 || dout !== last_product) begin
                if (k != 0) total++;
                bad++;
                $display("FAIL flush_busy after cycle %0d: done=%b stall=%b data=%h, required 0 0 %h",
                         k, done, stall, dout, last_product);
            end
        end
        $display("flush_busy: 3x5 aborted at BUSY cycle 10");
    endtask

    task automatic test_flush_done();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom; b = $urandom;
        next_cycle();
        start = 1'b1; alu_ctrl = ALU_MUL; d1 = a; d2 = b; flush = 1'b0;
        for (int cyc = 1; cyc <= N; cyc++) begin
            next_cycle();
        end
        next_cycle();
        flush = 1'b1; start = 1'b0; alu_ctrl = ALU_ADD;
        #1;
        total++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_done: done=%b stall=%b, required 0 0", done, stall);
        end
        next_cycle();
        flush = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_done after: done=%b stall=%b, required 0 0", done, stall);
        end
        last_product = ref_product(a, b);
        $display("flush_done: %h * %h", a, b);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = (i == 0) ? '0 : $urandom;
            issue_mul(a, b, 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_busy();
        next_cycle();
        start = 1'b1; alu_ctrl = ALU_MUL; d1 = 32'd11; d2 = 32'd13; flush = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) next_cycle();
        rst = 1'b1; start = 1'b0; alu_ctrl = ALU_ADD;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy stall: got %b, required 0", stall);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || stall !== 1'b0 || dout !== '0) begin
            bad++;
            $display("FAIL reset_mid_busy after: done=%b stall=%b data=%h, required 0 0 0", done, stall, dout);
        end
        last_product = '0;
        $display("reset_mid_busy: checked");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_ctrl = ALU_ADD; d1 = '0; d2 = '0; flush = 1'b0;
        last_product = '0;
        test_reset();
        test_basic_mul();
        test_non_mul();
        test_truncation();
        test_back_to_back();
        test_flush_busy();
        test_flush_done();
        test_non_mul();
        test_random();
        test_reset_mid_busy();
        issue_mul(32'd3, 32'd5, 1'b0, "post_reset_3x5");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
